periph_bus: RTL and testbench
=============================

PERIPH_BUS -- requirements
Module: periph_bus

Interface
REQ-001 SHALL have the following ports; clock and reset are listed first.
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
REQ-002 SHALL have these ports:
- MemRead  in  1  MEM-stage load strobe.
- MemWrite  in  1  MEM-stage store strobe.
- Addr  in  32  byte address from ALUResult of the MEM stage.
- WriteData  in  32  store data.
- ReadData  out  32  load data, feeding the MEM_WB register.
- switch  in  8  board switches.
- led  out  8  board LEDs.
- digi  out  12  seven-segment drive: [11:8] anode select, [7:0] segments.
- irqout  out  1  timer interrupt request to the PC/IRQ logic.

Function
REQ-003 SHALL decode word addresses; Addr[1:0] is ignored. Register map:
- TH 0x40000000 RW
- TL 0x40000004 RW
- TCON 0x40000008 RW, bits [2:0]; upper bits read 0
- led 0x4000000C RW
- switch 0x40000010 RO
- digi 0x40000014 RW
- systick 0x40000018 RO (see Configuration)
REQ-004 ReadData SHALL be combinational and valid in the same cycle as MemRead=1. It SHALL be 0 when MemRead=0 or the address is unmapped.
REQ-005 A write SHALL take effect at the rising edge where MemWrite=1. Writes to RO or unmapped addresses SHALL be ignored.
REQ-006 TCON bits SHALL be [0] timer enable, [1] interrupt enable, [2] interrupt status.
REQ-007 Timer behaviour when TCON[0]=1, each cycle:
- if TL==0xFFFFFFFF: TL<=TH, and TCON[2]<=1 when TCON[1]=1;
- otherwise TL<=TL+1, wrapping modulo 2^32.
REQ-008 When TCON[0]=0, TL and TCON[2] SHALL hold.
REQ-009 irqout SHALL equal TCON[1] & TCON[2], registered only via TCON, with no extra latency.
REQ-010 TCON[2] SHALL be cleared only by a software write of 0 to TCON[2] or by reset.
REQ-011 If a CPU write to TL or TCON coincides with a timer update in the same cycle, the CPU write SHALL win for that register.
REQ-012 A write to TH SHALL NOT alter TL. The reload value used SHALL be the TH value before the edge.
REQ-013 led and digi SHALL be driven directly from their registers.

Reset
REQ-014 On reset=1 the following SHALL be 0 immediately, independent of clk: TH, TL, TCON, led, digi, systick, irqout.
REQ-015 Reset deasserted mid-count SHALL restart from TL=0 with the timer disabled.

Configuration
REQ-016 Macro PERIPH_SYSTICK_EN behaviour:
- Defined: systick is a 32-bit counter incrementing every cycle, wrapping, readable at 0x40000018.
- Undefined: no counter is built, and 0x40000018 reads 0 as unmapped.

Structure
REQ-017 Package periph_pkg SHALL hold the address constants, the TCON bit indices, and the register-width constants.
REQ-018 Sub-module periph_timer SHALL contain TH/TL/TCON, the reload logic and irqout. periph_bus SHALL hold the decode, the led/digi registers and the read mux.

Verification
REQ-019 Reload and interrupt: write TH=0xFFFFFFFE, TL=0xFFFFFFFE, TCON=3.
- Cycles 1–2 later: TL reads 0xFFFFFFFF, then 0xFFFFFFFE.
- Cycle 2: irqout=1 and stays 1.
- Then write TCON=3: irqout=0 next cycle.
REQ-020 Interrupt disabled: same setup with TCON=1 -> TL reloads and irqout stays 0 for 10 cycles.
REQ-021 Write collision: TL=0xFFFFFFFF, TCON=3, and in that same cycle write TCON=1 -> TCON reads 1, irqout=0.
REQ-022 I/O paths:
- switch=0xA5, load 0x40000010 -> ReadData=0x000000A5.
- Store 0x3C to 0x4000000C -> led=0x3C.
- Store to 0x40000010 -> no change.
REQ-023 Unmapped and reset:
- Load 0x40000020 -> ReadData=0.
- Assert reset asynchronously mid-count -> TL, TCON, led and irqout read 0 before the next clk edge.
REQ-024 With PERIPH_SYSTICK_EN defined, two loads of 0x40000018 taken 5 cycles apart SHALL differ by 5. Without the macro, both SHALL read 0.

Source files
------------

// File: rtl/periph_pkg.sv
// periph_pkg -- shared constants for the memory-mapped peripheral block.
//   Register widths, word-aligned register addresses, TCON bit indices,
//   a register-select enum and the address decode helper.
package periph_pkg;

  localparam int DATA_W = 32;
  localparam int LED_W  = 8;
  localparam int DIGI_W = 12;
  localparam int TCON_W = 3;

  localparam logic [DATA_W-1:0] ADDR_TH      = 32'h4000_0000;
  localparam logic [DATA_W-1:0] ADDR_TL      = 32'h4000_0004;
  localparam logic [DATA_W-1:0] ADDR_TCON    = 32'h4000_0008;
  localparam logic [DATA_W-1:0] ADDR_LED     = 32'h4000_000C;
  localparam logic [DATA_W-1:0] ADDR_SWITCH  = 32'h4000_0010;
  localparam logic [DATA_W-1:0] ADDR_DIGI    = 32'h4000_0014;
  localparam logic [DATA_W-1:0] ADDR_SYSTICK = 32'h4000_0018;

  localparam int TCON_EN = 0;  // timer enable
  localparam int TCON_IE = 1;  // interrupt enable
  localparam int TCON_IS = 2;  // interrupt status (sticky)

  typedef enum logic [2:0] {
    SEL_NONE, SEL_TH, SEL_TL, SEL_TCON, SEL_LED, SEL_SWITCH, SEL_DIGI, SEL_SYSTICK
  } reg_sel_e;

  // Word decode: only Addr[31:2] takes part, byte offset is ignored.
  function automatic reg_sel_e decode(input logic [DATA_W-3:0] word);
    reg_sel_e sel;
    sel = SEL_NONE;
    if      (word == ADDR_TH[DATA_W-1:2])      sel = SEL_TH;
    else if (word == ADDR_TL[DATA_W-1:2])      sel = SEL_TL;
    else if (word == ADDR_TCON[DATA_W-1:2])    sel = SEL_TCON;
    else if (word == ADDR_LED[DATA_W-1:2])     sel = SEL_LED;
    else if (word == ADDR_SWITCH[DATA_W-1:2])  sel = SEL_SWITCH;
    else if (word == ADDR_DIGI[DATA_W-1:2])    sel = SEL_DIGI;
    else if (word == ADDR_SYSTICK[DATA_W-1:2]) sel = SEL_SYSTICK;
    return sel;
  endfunction

endpackage

// File: rtl/periph_timer.sv
// periph_timer -- reloadable up-counter with sticky interrupt.
//   clk, reset       : clock, async active-high reset
//   wr_th/wr_tl/wr_tcon, wdata : CPU register writes
//   th, tl, tcon     : register contents for read-back
//   irqout           : TCON.IE & TCON.IS, straight from the register
module periph_timer
  import periph_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_th,
  input  logic              wr_tl,
  input  logic              wr_tcon,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] th,
  output logic [DATA_W-1:0] tl,
  output logic [TCON_W-1:0] tcon,
  output logic              irqout
);

  logic tl_full;
  assign tl_full = (tl == {DATA_W{1'b1}});

  // CPU writes take priority over the counter; the reload samples th
  // before the edge, so a simultaneous TH write only affects later reloads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th   <= '0;
      tl   <= '0;
      tcon <= '0;
    end else begin
      if (wr_th) th <= wdata;

      if (wr_tl)              tl <= wdata;
      else if (tcon[TCON_EN]) tl <= tl_full ? th : tl + DATA_W'(1);

      if (wr_tcon)
        tcon <= wdata[TCON_W-1:0];
      else if (tcon[TCON_EN] && tcon[TCON_IE] && tl_full)
        tcon[TCON_IS] <= 1'b1;
    end
  end

  assign irqout = tcon[TCON_IE] & tcon[TCON_IS];

endmodule

// File: rtl/periph_bus.sv
// periph_bus -- MEM-stage peripheral bus: decode, LED/7-seg registers,
//   timer instance and combinational read mux.
//   clk, reset : clock, async active-high reset
//   MemRead, MemWrite, Addr, WriteData : CPU access from the MEM stage
//   ReadData   : load data (0 when not reading or unmapped)
//   switch/led/digi : board I/O, irqout : timer interrupt
// Optional: define PERIPH_SYSTICK_EN to build a free-running cycle counter
//   readable at 0x40000018; otherwise that address reads 0.
module periph_bus
  import periph_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [DATA_W-1:0] Addr,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  input  logic [LED_W-1:0]  switch,
  output logic [LED_W-1:0]  led,
  output logic [DIGI_W-1:0] digi,
  output logic              irqout
);

  reg_sel_e          sel;
  logic [DATA_W-1:0] th, tl;
  logic [TCON_W-1:0] tcon;
  logic              unused_addr_lsb;

  assign sel             = decode(Addr[DATA_W-1:2]);
  assign unused_addr_lsb = ^Addr[1:0];

  periph_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .wr_th   (MemWrite && sel == SEL_TH),
    .wr_tl   (MemWrite && sel == SEL_TL),
    .wr_tcon (MemWrite && sel == SEL_TCON),
    .wdata   (WriteData),
    .th      (th),
    .tl      (tl),
    .tcon    (tcon),
    .irqout  (irqout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led  <= '0;
      digi <= '0;
    end else if (MemWrite) begin
      if (sel == SEL_LED)  led  <= WriteData[LED_W-1:0];
      if (sel == SEL_DIGI) digi <= WriteData[DIGI_W-1:0];
    end
  end

`ifdef PERIPH_SYSTICK_EN
  logic [DATA_W-1:0] systick;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) systick <= '0;
    else       systick <= systick + DATA_W'(1);
  end
`endif

  always_comb begin
    ReadData = '0;
    if (MemRead) begin
      case (sel)
        SEL_TH:      ReadData = th;
        SEL_TL:      ReadData = tl;
        SEL_TCON:    ReadData = DATA_W'(tcon);
        SEL_LED:     ReadData = DATA_W'(led);
        SEL_SWITCH:  ReadData = DATA_W'(switch);
        SEL_DIGI:    ReadData = DATA_W'(digi);
`ifdef PERIPH_SYSTICK_EN
        SEL_SYSTICK: ReadData = systick;
`endif
        default:     ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_periph_bus.sv
module tb_periph_bus;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [31:0] Addr, WriteData, ReadData;
  logic [7:0]  switch, led;
  logic [11:0] digi;
  logic        irqout;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  localparam logic [31:0] A_TH = 32'h4000_0000, A_TL = 32'h4000_0004,
                          A_TCON = 32'h4000_0008, A_LED = 32'h4000_000C,
                          A_SW = 32'h4000_0010, A_DIGI = 32'h4000_0014,
                          A_TICK = 32'h4000_0018;

  periph_bus dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Addr(Addr), .WriteData(WriteData), .ReadData(ReadData),
    .switch(switch), .led(led), .digi(digi), .irqout(irqout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Store: starts just after a negedge, write lands on the next posedge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemRead = 1'b0; MemWrite = 1'b1; Addr = a; WriteData = d;
    @(negedge clk);
    MemWrite = 1'b0;
  endtask

  // Load: expectation queued with the request, checked when data settles.
  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] e);
    MemWrite = 1'b0; MemRead = 1'b1; Addr = a;
    exp_q.push_back(e); tag_q.push_back(tag);
    #1;
    chk(tag_q.pop_front(), ReadData, exp_q.pop_front());
    MemRead = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] v1, v2, tl_exp;

  initial begin
    reset = 1'b1; MemRead = 0; MemWrite = 0; Addr = 0; WriteData = 0; switch = 8'hA5;
    #3;
    chk("rst_led", {24'b0, led}, 0);
    chk("rst_digi", {20'b0, digi}, 0);
    chk("rst_irq", {31'b0, irqout}, 0);
    rd("rst_tl", A_TL, 0);
    rd("rst_tcon", A_TCON, 0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);

    // reload with interrupt
    wr(A_TH, 32'hFFFF_FFFE);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 3);
    idle(1);
    rd("c1_tl", A_TL, 32'hFFFF_FFFF);
    chk("c1_irq", {31'b0, irqout}, 0);
    idle(1);
    rd("c2_tl", A_TL, 32'hFFFF_FFFE);
    chk("c2_irq", {31'b0, irqout}, 1);
    idle(3);
    chk("irq_sticky", {31'b0, irqout}, 1);
    rd("tcon_is", A_TCON, 7);
    wr(A_TCON, 3);
    chk("irq_clr", {31'b0, irqout}, 0);
    rd("tcon_clr", A_TCON, 3);

    // interrupt disabled: reload still runs, irq never fires
    wr(A_TCON, 0);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 1);
    tl_exp = 32'hFFFF_FFFE;
    for (int i = 0; i < 10; i++) begin
      idle(1);
      tl_exp = (tl_exp == 32'hFFFF_FFFF) ? 32'hFFFF_FFFE : tl_exp + 1;
      rd("noie_tl", A_TL, tl_exp);
      chk("noie_irq", {31'b0, irqout}, 0);
    end

    // write collision: TCON write wins over the IS set
    wr(A_TCON, 0);
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TCON, 3);
    wr(A_TCON, 1);
    rd("coll_tcon", A_TCON, 1);
    chk("coll_irq", {31'b0, irqout}, 0);
    rd("coll_tl", A_TL, 32'hFFFF_FFFE);

    // disabled timer holds; TH write leaves TL alone
    wr(A_TCON, 0);
    wr(A_TL, 32'h5);
    wr(A_TH, 32'h1234);
    idle(3);
    rd("tl_hold", A_TL, 32'h5);
    rd("th_rb", A_TH, 32'h1234);

    // reload uses TH value from before a coincident TH write
    wr(A_TH, 32'h100);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 1);
    idle(1);
    wr(A_TH, 32'h200);
    rd("reload_oldth", A_TL, 32'h100);
    wr(A_TCON, 0);

    // I/O paths and decode
    rd("switch", A_SW, 32'hA5);
    wr(A_LED, 32'h3C);
    chk("led_pin", {24'b0, led}, 32'h3C);
    rd("led_rb", A_LED, 32'h3C);
    rd("addr_lsb", A_LED | 32'h3, 32'h3C);
    wr(A_SW, 32'hFF);
    rd("sw_ro", A_SW, 32'hA5);
    chk("led_keep", {24'b0, led}, 32'h3C);
    wr(A_DIGI, 32'hFFFF_FABC);
    chk("digi_pin", {20'b0, digi}, 32'hABC);
    rd("digi_rb", A_DIGI, 32'hABC);
    rd("unmapped", 32'h4000_0020, 0);
    MemRead = 0; Addr = A_LED; #1;
    chk("noread", ReadData, 0);

`ifdef PERIPH_SYSTICK_EN
    MemRead = 1; Addr = A_TICK; #1; v1 = ReadData;
    idle(5);
    #1; v2 = ReadData; MemRead = 0;
    chk("systick_diff", v2 - v1, 5);
`else
    rd("systick0_a", A_TICK, 0);
    idle(5);
    rd("systick0_b", A_TICK, 0);
`endif

    // async reset mid-count with irq pending
    wr(A_TH, 32'hFFFF_FFFE);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 3);
    idle(2);
    chk("pre_rst_irq", {31'b0, irqout}, 1);
    #2; reset = 1'b1; #1;
    chk("arst_irq", {31'b0, irqout}, 0);
    chk("arst_led", {24'b0, led}, 0);
    chk("arst_digi", {20'b0, digi}, 0);
    rd("arst_tl", A_TL, 0);
    rd("arst_tcon", A_TCON, 0);
    rd("arst_th", A_TH, 0);
    @(negedge clk); reset = 1'b0;
    idle(3);
    rd("post_rst_tl", A_TL, 0);
    rd("post_rst_tcon", A_TCON, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
